// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register: captures the decoded slot, supports freeze (hold),
// flush (bubble insertion) and keeps a saturating count of inserted bubbles.
module id_exe_stage_reg #(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              valid_in,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       val_rn_in,
    input  logic [31:0]       val_rm_in,
    input  logic [3:0]        dest_in,
    input  logic [3:0]        src1_in,
    input  logic [3:0]        src2_in,
    input  logic [3:0]        exe_cmd_in,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              b_in,
    input  logic              s_in,
    input  logic              imm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm_24_in,
    input  logic [3:0]        status_in,
    output logic              valid_out,
    output logic [31:0]       pc_out,
    output logic [31:0]       val_rn_out,
    output logic [31:0]       val_rm_out,
    output logic [3:0]        dest_out,
    output logic [3:0]        src1_out,
    output logic [3:0]        src2_out,
    output logic [3:0]        exe_cmd_out,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic              b_out,
    output logic              s_out,
    output logic              imm_out,
    output logic [11:0]       shift_operand_out,
    output logic [23:0]       signed_imm_24_out,
    output logic [3:0]        status_out,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  exe_cmd;
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        b;
        logic        s;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        logic [3:0]  status;
    } slot_t;

    slot_t             slot_q, slot_d, slot_in;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Assemble the incoming slot; side-effecting control bits are masked on an empty slot.
    always_comb begin
        slot_in               = '0;
        slot_in.valid         = valid_in;
        slot_in.pc            = pc_in;
        slot_in.val_rn        = val_rn_in;
        slot_in.val_rm        = val_rm_in;
        slot_in.dest          = dest_in;
        slot_in.src1          = src1_in;
        slot_in.src2          = src2_in;
        slot_in.exe_cmd       = exe_cmd_in;
        slot_in.wb_en         = wb_en_in    & valid_in;
        slot_in.mem_r_en      = mem_r_en_in & valid_in;
        slot_in.mem_w_en      = mem_w_en_in & valid_in;
        slot_in.b             = b_in        & valid_in;
        slot_in.s             = s_in        & valid_in;
        slot_in.imm           = imm_in;
        slot_in.shift_operand = shift_operand_in;
        slot_in.signed_imm_24 = signed_imm_24_in;
        slot_in.status        = status_in;
    end

    // Next-state selection: flush beats freeze beats load; counter saturates.
    always_comb begin
        slot_d = slot_q;
        cnt_d  = cnt_q;
        if (flush) begin
            slot_d = '0;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (!freeze) begin
            slot_d = slot_in;
        end
    end

    // Stage register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
            cnt_q  <= '0;
        end else begin
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
        end
    end

    assign valid_out         = slot_q.valid;
    assign pc_out            = slot_q.pc;
    assign val_rn_out        = slot_q.val_rn;
    assign val_rm_out        = slot_q.val_rm;
    assign dest_out          = slot_q.dest;
    assign src1_out          = slot_q.src1;
    assign src2_out          = slot_q.src2;
    assign exe_cmd_out       = slot_q.exe_cmd;
    assign wb_en_out         = slot_q.wb_en;
    assign mem_r_en_out      = slot_q.mem_r_en;
    assign mem_w_en_out      = slot_q.mem_w_en;
    assign b_out             = slot_q.b;
    assign s_out             = slot_q.s;
    assign imm_out           = slot_q.imm;
    assign shift_operand_out = slot_q.shift_operand;
    assign signed_imm_24_out = slot_q.signed_imm_24;
    assign status_out        = slot_q.status;
    assign bubble_cnt        = cnt_q;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Randomized self-checking bench for id_exe_stage_reg against a behavioural model.
`timescale 1ns/1ps
module tb_id_exe_stage_reg;

    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_SAT = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, flush, freeze, valid_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic [3:0]  dest_in, src1_in, src2_in, exe_cmd_in, status_in;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;

    logic        valid_out;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic [3:0]  dest_out, src1_out, src2_out, exe_cmd_out, status_out;
    logic        wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm_24_out;
    logic [CNT_W-1:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_exe_stage_reg #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .valid_in(valid_in),
        .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
        .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .exe_cmd_in(exe_cmd_in),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .b_in(b_in), .s_in(s_in), .imm_in(imm_in),
        .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
        .status_in(status_in),
        .valid_out(valid_out), .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
        .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out), .exe_cmd_out(exe_cmd_out),
        .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .b_out(b_out), .s_out(s_out), .imm_out(imm_out),
        .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
        .status_out(status_out), .bubble_cnt(bubble_cnt)
    );

    wire [158:0] obs = {valid_out, pc_out, val_rn_out, val_rm_out, dest_out, src1_out,
                        src2_out, exe_cmd_out, wb_en_out, mem_r_en_out, mem_w_en_out,
                        b_out, s_out, imm_out, shift_operand_out, signed_imm_24_out, status_out};

    // Behavioural model: expected contents as plain variables, bubble count as an integer.
    logic        m_valid, m_wb, m_mr, m_mw, m_b, m_s, m_imm;
    logic [31:0] m_pc, m_rn, m_rm;
    logic [3:0]  m_dest, m_src1, m_src2, m_cmd, m_st;
    logic [11:0] m_sh;
    logic [23:0] m_si;
    int          m_cnt;

    function automatic logic [158:0] exp_vec();
        return {m_valid, m_pc, m_rn, m_rm, m_dest, m_src1, m_src2, m_cmd,
                m_wb, m_mr, m_mw, m_b, m_s, m_imm, m_sh, m_si, m_st};
    endfunction

    task automatic model_clear();
        {m_valid, m_pc, m_rn, m_rm, m_dest, m_src1, m_src2, m_cmd,
         m_wb, m_mr, m_mw, m_b, m_s, m_imm, m_sh, m_si, m_st} = '0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_clear();
            m_cnt = 0;
        end else if (flush) begin
            model_clear();
            if (m_cnt < CNT_SAT) m_cnt = m_cnt + 1;
        end else if (!freeze) begin
            m_valid = valid_in;
            m_pc = pc_in; m_rn = val_rn_in; m_rm = val_rm_in;
            m_dest = dest_in; m_src1 = src1_in; m_src2 = src2_in; m_cmd = exe_cmd_in;
            m_imm = imm_in; m_sh = shift_operand_in; m_si = signed_imm_24_in; m_st = status_in;
            m_wb = valid_in ? wb_en_in : 1'b0;
            m_mr = valid_in ? mem_r_en_in : 1'b0;
            m_mw = valid_in ? mem_w_en_in : 1'b0;
            m_b  = valid_in ? b_in : 1'b0;
            m_s  = valid_in ? s_in : 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_inputs();
        valid_in = 1'($urandom); pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom;
        dest_in = 4'($urandom); src1_in = 4'($urandom); src2_in = 4'($urandom);
        exe_cmd_in = 4'($urandom); status_in = 4'($urandom);
        wb_en_in = 1'($urandom); mem_r_en_in = 1'($urandom); mem_w_en_in = 1'($urandom);
        b_in = 1'($urandom); s_in = 1'($urandom); imm_in = 1'($urandom);
        shift_operand_in = 12'($urandom); signed_imm_24_in = 24'($urandom);
    endtask

    task automatic test_reset();
        rand_inputs(); rst = 1'b1; flush = 1'b1; freeze = 1'b1;
        tick();
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", obs);
        end
        checks++;
        if (bubble_cnt !== '0) begin
            errors++; $display("FAIL reset_cnt got %0d want 0", bubble_cnt);
        end
        rst = 1'b0; flush = 1'b0; freeze = 1'b0;
    endtask

    task automatic test_load();
        rand_inputs();
        valid_in = 1'b1; pc_in = 32'h0000_0008; val_rn_in = 32'h1234_5678;
        dest_in = 4'd4; wb_en_in = 1'b1; exe_cmd_in = 4'h1;
        tick();
        checks++;
        if (pc_out !== 32'h8 || val_rn_out !== 32'h1234_5678 || dest_out !== 4'd4 ||
            wb_en_out !== 1'b1 || exe_cmd_out !== 4'h1 || valid_out !== 1'b1) begin
            errors++; $display("FAIL load_fields pc %h rn %h dest %0d wb %b cmd %h v %b",
                               pc_out, val_rn_out, dest_out, wb_en_out, exe_cmd_out, valid_out);
        end
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL load_model got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_freeze();
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs(); pc_in = 32'hFFFF_FFFF;
            tick();
            checks++;
            if (pc_out !== 32'h8 || valid_out !== 1'b1) begin
                errors++; $display("FAIL freeze_hold cycle %0d pc %h v %b want 00000008 1",
                                   i, pc_out, valid_out);
            end
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL freeze_model got %h want %h", obs, exp_vec());
            end
        end
        freeze = 1'b0;
    endtask

    task automatic test_flush_freeze();
        int prev;
        rand_inputs(); valid_in = 1'b1; mem_w_en_in = 1'b1;
        tick();
        checks++;
        if (mem_w_en_out !== 1'b1 || valid_out !== 1'b1) begin
            errors++; $display("FAIL ff_setup mw %b v %b want 1 1", mem_w_en_out, valid_out);
        end
        prev = m_cnt;
        rand_inputs(); valid_in = 1'b1; flush = 1'b1; freeze = 1'b1;
        tick();
        checks++;
        if (valid_out !== 1'b0 || mem_w_en_out !== 1'b0 || pc_out !== 32'h0 ||
            int'(bubble_cnt) != prev + 1) begin
            errors++; $display("FAIL flush_freeze v %b mw %b pc %h cnt %0d want 0 0 0 %0d",
                               valid_out, mem_w_en_out, pc_out, bubble_cnt, prev + 1);
        end
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL flush_all_zero got %h want 0", obs);
        end
        flush = 1'b0; freeze = 1'b0;
    endtask

    task automatic test_invalid_slot();
        rand_inputs();
        valid_in = 1'b0; wb_en_in = 1'b1; b_in = 1'b1; mem_r_en_in = 1'b1;
        mem_w_en_in = 1'b1; s_in = 1'b1; val_rm_in = 32'hA5A5_A5A5;
        tick();
        checks++;
        if (wb_en_out !== 1'b0 || b_out !== 1'b0 || mem_r_en_out !== 1'b0 ||
            mem_w_en_out !== 1'b0 || s_out !== 1'b0 || valid_out !== 1'b0 ||
            val_rm_out !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL invalid_slot wb %b b %b mr %b mw %b s %b v %b rm %h",
                               wb_en_out, b_out, mem_r_en_out, mem_w_en_out, s_out,
                               valid_out, val_rm_out);
        end
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL invalid_model got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_saturation();
        rst = 1'b1; tick(); rst = 1'b0;
        flush = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            rand_inputs(); freeze = 1'($urandom);
            tick();
            checks++;
            if (int'(bubble_cnt) != ((k < CNT_SAT) ? k : CNT_SAT)) begin
                errors++; $display("FAIL saturation edge %0d cnt %0d want %0d",
                                   k, bubble_cnt, (k < CNT_SAT) ? k : CNT_SAT);
            end
        end
        flush = 1'b0; freeze = 1'b0;
    endtask

    task automatic test_sync_reset();
        rand_inputs(); valid_in = 1'b1; tick();
        // Raise rst mid-cycle: nothing may change before the next edge.
        rst = 1'b1; #3;
        checks++;
        if (obs !== exp_vec() || valid_out !== 1'b1) begin
            errors++; $display("FAIL rst_no_edge got %h want %h", obs, exp_vec());
        end
        rst = 1'b0;
        freeze = 1'b1; tick();
        rst = 1'b1; rand_inputs(); tick();
        checks++;
        if (obs !== '0 || bubble_cnt !== '0) begin
            errors++; $display("FAIL rst_in_freeze got %h cnt %0d want 0 0", obs, bubble_cnt);
        end
        rst = 1'b0; freeze = 1'b0;
        rand_inputs(); valid_in = 1'b1; pc_in = 32'hCAFE_0004;
        tick();
        checks++;
        if (pc_out !== 32'hCAFE_0004 || valid_out !== 1'b1 || obs !== exp_vec()) begin
            errors++; $display("FAIL load_after_rst pc %h v %b want cafe0004 1", pc_out, valid_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            rst    = ($urandom_range(99) < 3);
            flush  = ($urandom_range(99) < 15);
            freeze = ($urandom_range(99) < 25);
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random_data cycle %0d got %h want %h", i, obs, exp_vec());
            end
            checks++;
            if (int'(bubble_cnt) != m_cnt) begin
                errors++; $display("FAIL random_cnt cycle %0d got %0d want %0d", i, bubble_cnt, m_cnt);
            end
            checks++;
            if (!valid_out && (wb_en_out | mem_r_en_out | mem_w_en_out | b_out | s_out)) begin
                errors++; $display("FAIL invariant cycle %0d ctrl %b%b%b%b%b want 00000", i,
                                   wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out);
            end
        end
        rst = 1'b0; flush = 1'b0; freeze = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; freeze = 1'b0;
        rand_inputs();
        model_clear(); m_cnt = 0;
        test_reset();
        test_load();
        test_freeze();
        test_flush_freeze();
        test_invalid_slot();
        test_saturation();
        test_sync_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_exe_stage_reg.md
ID_EXE_STAGE_REG -- requirements
Module: id_exe_stage_reg

Interface
REQ-001 Parameter: CNT_W, 16, width of the bubble counter.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 flush  input  1  branch-taken kill; converts the captured slot into a bubble.
REQ-005 freeze  input  1  hold all stage contents (EXE/MEM stall).
REQ-006 valid_in  input  1  ID slot carries a real instruction.
REQ-007 pc_in  input  32  PC+4 of the decoded instruction.
REQ-008 val_rn_in, val_rm_in  input  32 each  register-file read data for src1/src2.
REQ-009 dest_in, src1_in, src2_in  input  4 each  destination and source register indices.
REQ-010 exe_cmd_in  input  4  ALU command.
REQ-011 wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in  input  1 each  control bits.
REQ-012 shift_operand_in  input  12  operand-2 field; signed_imm_24_in  input  24  branch offset.
REQ-013 status_in  input  4  NZCV flags from the status register.
REQ-014 Outputs: one registered *_out port per *_in port above (same width, same meaning), plus valid_out (1).
REQ-015 bubble_cnt  output  CNT_W  count of bubbles inserted by flush.

Function
REQ-016 Every output SHALL be a flop; no combinational path from any input to any output.
REQ-017 Update priority per rising edge SHALL be: rst > flush > freeze > load.
REQ-018 Load (no rst/flush/freeze): every *_out takes its *_in; valid_out takes valid_in; latency exactly 1 cycle.
REQ-019 Freeze (no rst/flush): all *_out and valid_out SHALL hold their previous values; bubble_cnt holds.
REQ-020 Flush: valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out SHALL become 0; all data fields (pc, val_rn, val_rm, dest, src1, src2, exe_cmd, imm, shift_operand, signed_imm_24, status) SHALL become 0.
REQ-021 Flush and freeze asserted together: flush wins (bubble inserted, not hold).
REQ-022 When valid_in=0 on a load, control bits wb_en, mem_r_en, mem_w_en, b, s SHALL be captured as 0 regardless of their input values; data fields load normally.
REQ-023 Invariant: valid_out=0 implies wb_en_out=mem_r_en_out=mem_w_en_out=b_out=s_out=0.
REQ-024 bubble_cnt SHALL increment by 1 on each edge where flush=1 and rst=0, independent of freeze and valid_in.
REQ-025 bubble_cnt SHALL saturate at 2^CNT_W-1; further flushes leave it unchanged (no wrap).
REQ-026 src1_out/src2_out SHALL be held and flushed identically to other data fields (consumed by forwarding/hazard logic).

Reset
REQ-027 On a rising edge with rst=1, all outputs including valid_out and bubble_cnt SHALL become 0, regardless of flush, freeze, valid_in.
REQ-028 Reset mid-freeze SHALL clear the held contents; after rst deasserts, the stage loads on the next edge unless flush/freeze asserted.
REQ-029 rst asserted without a clock edge SHALL have no effect (synchronous).

Verification
REQ-030 Load: rst low, valid_in=1, pc_in=0x0000_0008, val_rn_in=0x1234_5678, dest_in=4, wb_en_in=1, exe_cmd_in=0x1 -> next edge outputs equal inputs, valid_out=1.
REQ-031 Freeze: load as above, then freeze=1 for 3 edges with pc_in=0xFFFF_FFFF -> pc_out stays 0x0000_0008, valid_out=1 for all 3 cycles.
REQ-032 Flush+freeze: stage holding valid instruction with mem_w_en_out=1, assert flush=1, freeze=1 -> next edge valid_out=0, mem_w_en_out=0, pc_out=0, bubble_cnt increments by 1.
REQ-033 Invalid slot: valid_in=0, wb_en_in=1, b_in=1, val_rm_in=0xA5A5_A5A5 -> wb_en_out=0, b_out=0, val_rm_out=0xA5A5_A5A5, valid_out=0.
REQ-034 Saturation: CNT_W=4, 20 consecutive flush edges -> bubble_cnt reaches 15 after 15 edges, remains 15.
REQ-035 Reset: during freeze with valid contents, rst=1 for one edge -> all outputs 0 on that edge; rst=0 with new inputs -> loaded next edge.
